// File: rtl/matrix_op_selector_pkg.sv
// Encodings shared with the switch-to-mode decoder: operation / calculation
// type enums and the rule deciding which pairings are meaningful.
package matrix_op_selector_pkg;

    typedef enum logic [2:0] {
        TRANSPOSE  = 3'd0,
        ADD        = 3'd1,
        MUL        = 3'd2,
        SCALAR_MUL = 3'd3,
        CONV       = 3'd4
    } op_mode_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        DOUBLE = 3'd1,
        SCALAR = 3'd2
    } calc_type_t;

    // Unknown codes on either field are never legal.
    function automatic logic pair_is_legal(input logic [2:0] op, input logic [2:0] ct);
        logic ok;
        ok = 1'b0;
        case (op)
            TRANSPOSE:  ok = (ct == SINGLE);
            ADD:        ok = (ct == DOUBLE);
            MUL:        ok = (ct == DOUBLE);
            SCALAR_MUL: ok = (ct == SCALAR);
            CONV:       ok = (ct == SINGLE);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/seven_seg_pkg.sv
// Seven-segment character set for the operation display.
// Segment byte layout: bit0=a ... bit6=g, bit7=dp, active-high.
package seven_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_T     = 8'h78;  // t : d e f g
    localparam logic [7:0] SEG_R     = 8'h50;  // r : e g
    localparam logic [7:0] SEG_A_UP  = 8'h77;  // A : a b c e f g
    localparam logic [7:0] SEG_N     = 8'h54;  // n : c e g
    localparam logic [7:0] SEG_D     = 8'h5E;  // d : b c d e g
    localparam logic [7:0] SEG_U     = 8'h1C;  // u : c d e
    localparam logic [7:0] SEG_L     = 8'h38;  // L : d e f
    localparam logic [7:0] SEG_S     = 8'h6D;  // S : a c d f g
    localparam logic [7:0] SEG_C_LO  = 8'h58;  // c : d e g
    localparam logic [7:0] SEG_O     = 8'h5C;  // o : c d e g
    localparam logic [7:0] SEG_V     = 8'h1C;  // v : c d e (same shape as u)
    localparam logic [7:0] SEG_C_UP  = 8'h39;  // C : a d e f
    localparam logic [7:0] SEG_E     = 8'h79;  // E : a d e f g
    // M has no true seven-segment form; an arch (a b c e f) is the usual stand-in.
    localparam logic [7:0] SEG_M     = 8'h37;

    // Four characters, element [0] is the leftmost digit.
    typedef logic [3:0][7:0] glyph4_t;

    localparam glyph4_t GLYPH_BLANK = {4{SEG_BLANK}};

    function automatic glyph4_t make_glyph(input logic [7:0] c0, input logic [7:0] c1,
                                           input logic [7:0] c2, input logic [7:0] c3);
        glyph4_t g;
        g[0] = c0;
        g[1] = c1;
        g[2] = c2;
        g[3] = c3;
        return g;
    endfunction

endpackage

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes a 4-character glyph onto a common 4-digit display.
// Each digit is lit for SCAN_DIV cycles; 'blank' darkens all anodes
// without disturbing the scan position.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  glyph4_t    glyph,
    input  logic       blank,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt_r;
    logic [1:0]       idx_r;
    logic [7:0]       seg_r;
    logic [3:0]       an_r;
    logic [7:0]       seg_s;
    logic [3:0]       an_s;

    // Free-running dwell counter and digit index; only reset touches them.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= {CNT_W{1'b0}};
            idx_r      <= 2'd0;
        end else if (scan_cnt_r == CNT_LAST) begin
            scan_cnt_r <= {CNT_W{1'b0}};
            idx_r      <= idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + CNT_W'(1);
        end
    end

    // Select the character and anode for the current digit; dp is never lit.
    always_comb begin
        seg_s = {1'b0, glyph[idx_r][6:0]};
        an_s  = 4'b1000 >> idx_r;
        if (blank) begin
            seg_s = 8'h00;
            an_s  = 4'b0000;
        end else begin
            seg_s = {1'b0, glyph[idx_r][6:0]};
            an_s  = 4'b1000 >> idx_r;
        end
    end

    // Register the pin drive so the display lines are glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= 8'h00;
            an_r  <= 4'b0000;
        end else begin
            seg_r <= seg_s;
            an_r  <= an_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule

// File: rtl/op_mode_display.sv
// Shows the selected matrix operation as a 4-character mnemonic and flags
// illegal op_mode/calc_type pairings. Every new selection is latched and,
// when OP_MODE_DISPLAY_BLINK_EN is defined, announced by a short blink.
// Without that macro the display never goes dark after the first load.
module op_mode_display
    import seven_seg_pkg::*;
    import matrix_op_selector_pkg::*;
#(
    parameter int SCAN_DIV     = 100000,
    parameter int BLINK_DIV    = 12500000,
    parameter int BLINK_HALVES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] op_mode,
    input  logic [2:0] calc_type,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       mode_err
);

    // Bit 6 set can never equal a sampled pair, so the first sample always loads.
    localparam logic [6:0] CUR_SENTINEL = 7'h40;

    logic [5:0] in_q_r;
    logic       in_vld_r;
    logic [6:0] cur_r;
    glyph4_t    glyph_r;
    logic       mode_err_r;

    logic       change_s;
    logic       legal_s;
    glyph4_t    glyph_s;
    logic       blank_s;

    function automatic glyph4_t glyph_for(input logic [2:0] op, input logic [2:0] ct);
        glyph4_t g;
        g = make_glyph(SEG_E, SEG_R, SEG_R, SEG_BLANK);
        if (pair_is_legal(op, ct)) begin
            case (op)
                TRANSPOSE:  g = make_glyph(SEG_T, SEG_R, SEG_A_UP, SEG_N);
                ADD:        g = make_glyph(SEG_BLANK, SEG_A_UP, SEG_D, SEG_D);
                MUL:        g = make_glyph(SEG_BLANK, SEG_M, SEG_U, SEG_L);
                SCALAR_MUL: g = make_glyph(SEG_S, SEG_C_LO, SEG_A_UP, SEG_L);
                CONV:       g = make_glyph(SEG_C_UP, SEG_O, SEG_N, SEG_V);
                default:    g = make_glyph(SEG_E, SEG_R, SEG_R, SEG_BLANK);
            endcase
        end else begin
            g = make_glyph(SEG_E, SEG_R, SEG_R, SEG_BLANK);
        end
        return g;
    endfunction

    // Input stage: sample the decoder outputs every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_q_r   <= 6'd0;
            in_vld_r <= 1'b0;
        end else begin
            in_q_r   <= {op_mode, calc_type};
            in_vld_r <= 1'b1;
        end
    end

    // Detect a new selection and look up its mnemonic and legality.
    always_comb begin
        change_s = 1'b0;
        if (in_vld_r) begin
            change_s = (cur_r != {1'b0, in_q_r});
        end else begin
            change_s = 1'b0;
        end
        legal_s = pair_is_legal(in_q_r[5:3], in_q_r[2:0]);
        glyph_s = glyph_for(in_q_r[5:3], in_q_r[2:0]);
    end

    // Latch the selection, its glyph and its error flag on every change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r      <= CUR_SENTINEL;
            glyph_r    <= GLYPH_BLANK;
            mode_err_r <= 1'b0;
        end else if (change_s) begin
            cur_r      <= {1'b0, in_q_r};
            glyph_r    <= glyph_s;
            mode_err_r <= ~legal_s;
        end else begin
            cur_r      <= cur_r;
            glyph_r    <= glyph_r;
            mode_err_r <= mode_err_r;
        end
    end

`ifdef OP_MODE_DISPLAY_BLINK_EN
    typedef enum logic [0:0] {
        STEADY = 1'b0,
        BLINK  = 1'b1
    } disp_state_t;

    localparam int HP_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int HALF_W = $clog2(BLINK_HALVES + 1);
    localparam logic [HP_W-1:0]   HP_LAST     = HP_W'(BLINK_DIV - 1);
    localparam logic [HALF_W-1:0] HALVES_INIT = HALF_W'(BLINK_HALVES);

    disp_state_t       state_r;
    disp_state_t       state_s;
    logic [HP_W-1:0]   hp_cnt_r;
    logic [HP_W-1:0]   hp_cnt_s;
    logic [HALF_W-1:0] half_cnt_r;
    logic [HALF_W-1:0] half_cnt_s;

    // Blink state and its two counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= STEADY;
            hp_cnt_r   <= {HP_W{1'b0}};
            half_cnt_r <= {HALF_W{1'b0}};
        end else begin
            state_r    <= state_s;
            hp_cnt_r   <= hp_cnt_s;
            half_cnt_r <= half_cnt_s;
        end
    end

    // A change always restarts a full blink; otherwise count down half-periods.
    always_comb begin
        state_s    = state_r;
        hp_cnt_s   = hp_cnt_r;
        half_cnt_s = half_cnt_r;
        if (change_s) begin
            state_s    = BLINK;
            hp_cnt_s   = {HP_W{1'b0}};
            half_cnt_s = HALVES_INIT;
        end else begin
            case (state_r)
                STEADY: begin
                    state_s    = STEADY;
                    hp_cnt_s   = {HP_W{1'b0}};
                    half_cnt_s = {HALF_W{1'b0}};
                end
                BLINK: begin
                    if (hp_cnt_r == HP_LAST) begin
                        hp_cnt_s   = {HP_W{1'b0}};
                        half_cnt_s = half_cnt_r - HALF_W'(1);
                        if (half_cnt_r == HALF_W'(1)) begin
                            state_s = STEADY;
                        end else begin
                            state_s = BLINK;
                        end
                    end else begin
                        hp_cnt_s = hp_cnt_r + HP_W'(1);
                    end
                end
                default: begin
                    state_s    = STEADY;
                    hp_cnt_s   = {HP_W{1'b0}};
                    half_cnt_s = {HALF_W{1'b0}};
                end
            endcase
        end
    end

    // Even number of halves remaining means the dark phase.
    always_comb begin
        blank_s = 1'b0;
        if (state_r == BLINK) begin
            blank_s = ~half_cnt_r[0];
        end else begin
            blank_s = 1'b0;
        end
    end
`else
    logic unused_cfg_s;

    // No blink hardware: the display is never blanked.
    always_comb begin
        blank_s      = 1'b0;
        unused_cfg_s = BLINK_DIV[0] ^ BLINK_HALVES[0];
    end
`endif

    seven_seg_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scanner (
        .clk  (clk),
        .rst  (rst),
        .glyph(glyph_r),
        .blank(blank_s),
        .seg  (seg),
        .an   (an)
    );

    assign mode_err = mode_err_r;

endmodule

// File: tb/tb_op_mode_display.sv
// Bench for op_mode_display: directed steps plus random selections, each
// cycle compared against a reference model that works from elapsed-cycle
// arithmetic (scan slot = cycles/SCAN_DIV mod 4, blink phase from cycles
// since the last latched change) and a character-level glyph table.
module tb_op_mode_display;
    import matrix_op_selector_pkg::*;

    localparam int SD = 4;
    localparam int BD = 8;
    localparam int BH = 2;

`ifdef OP_MODE_DISPLAY_BLINK_EN
    localparam bit BLINK_EN = 1'b1;
`else
    localparam bit BLINK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] op_mode = 3'd0;
    logic [2:0] calc_type = 3'd0;
    logic [7:0] seg;
    logic [3:0] an;
    logic       mode_err;

    int checks = 0;
    int errors = 0;

    // Model state: edges since reset release, the inputs seen at the last
    // two edges, and the edge at which the latched pair last changed.
    int         n = 0;
    logic [5:0] p1 = 6'd0;
    logic [5:0] p2 = 6'd0;
    int         lc = 0;
    bit         have_lc = 1'b0;
    logic [5:0] legal_tab [5];

    op_mode_display #(
        .SCAN_DIV(SD),
        .BLINK_DIV(BD),
        .BLINK_HALVES(BH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .op_mode(op_mode),
        .calc_type(calc_type),
        .seg(seg),
        .an(an),
        .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    function automatic string glyph_of(input logic [5:0] v);
        logic [2:0] o;
        logic [2:0] c;
        o = v[5:3];
        c = v[2:0];
        if (o == TRANSPOSE  && c == SINGLE) return "trAn";
        if (o == ADD        && c == DOUBLE) return " Add";
        if (o == MUL        && c == DOUBLE) return " MuL";
        if (o == SCALAR_MUL && c == SCALAR) return "ScAL";
        if (o == CONV       && c == SINGLE) return "Conv";
        return "Err ";
    endfunction

    function automatic logic [7:0] seg_of(input byte ch);
        case (ch)
            "t": return 8'h78;
            "r": return 8'h50;
            "A": return 8'h77;
            "n": return 8'h54;
            "d": return 8'h5E;
            "u": return 8'h1C;
            "v": return 8'h1C;
            "L": return 8'h38;
            "S": return 8'h6D;
            "c": return 8'h58;
            "o": return 8'h5C;
            "C": return 8'h39;
            "E": return 8'h79;
            "M": return 8'h37;
            " ": return 8'h00;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s n=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] o, input logic [2:0] c);
        op_mode   = o;
        calc_type = c;
    endtask

    // One clock: record inputs seen at the edge, then check outputs 1 time unit later.
    task automatic tick();
        logic [5:0] v;
        logic       r;
        int         idx;
        int         t;
        bit         dark;
        string      g;
        logic [3:0] ea;
        logic       eme;
        v = {op_mode, calc_type};
        r = rst;
        @(posedge clk);
        #1;
        if (r) begin
            n = 0;
            have_lc = 1'b0;
            check("seg_reset", seg, 8'h00);
            check("an_reset", {4'h0, an}, 8'h00);
            check("err_reset", {7'h00, mode_err}, 8'h00);
        end else begin
            n++;
            // Outputs now reflect the design state as of the previous edge.
            idx  = ((n - 1) / SD) % 4;
            g    = (n >= 3) ? glyph_of(p2) : "    ";
            dark = 1'b0;
            if (BLINK_EN && have_lc) begin
                t = (n - 1) - lc;
                if (t < BH * BD && ((BH - t / BD) % 2 == 0)) dark = 1'b1;
            end
            ea = dark ? 4'b0000 : (4'b1000 >> idx);
            check("an", {4'h0, an}, {4'h0, ea});
            if (!dark) check("seg", seg, seg_of(g[idx]));
            eme = (n >= 2) ? (glyph_of(p1) == "Err ") : 1'b0;
            check("mode_err", {7'h00, mode_err}, {7'h00, eme});
            if (n == 2 || (n >= 3 && p1 != p2)) begin
                lc = n;
                have_lc = 1'b1;
            end
            p2 = p1;
            p1 = v;
        end
    endtask

    initial begin
        legal_tab[0] = {TRANSPOSE, SINGLE};
        legal_tab[1] = {ADD, DOUBLE};
        legal_tab[2] = {MUL, DOUBLE};
        legal_tab[3] = {SCALAR_MUL, SCALAR};
        legal_tab[4] = {CONV, SINGLE};

        // Reset held 3 cycles with ADD/DOUBLE waiting on the inputs.
        drive(ADD, DOUBLE);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();

        // Illegal pairing, then its legal neighbour.
        drive(MUL, SCALAR);
        repeat (24) tick();
        drive(MUL, DOUBLE);
        repeat (12) tick();

        // Change while the previous blink is in its lit half, then again 3 cycles later.
        drive(CONV, SINGLE);
        repeat (3) tick();
        drive(TRANSPOSE, SINGLE);
        repeat (30) tick();

        // Random selections held for random durations.
        for (int k = 0; k < 25; k++) begin
            logic [5:0] rv;
            if ($urandom_range(0, 1) == 1) rv = legal_tab[$urandom_range(0, 4)];
            else rv = 6'($urandom_range(0, 63));
            drive(rv[5:3], rv[2:0]);
            repeat ($urandom_range(1, 25)) tick();
        end

        // Inputs changing every cycle.
        for (int k = 0; k < 12; k++) begin
            logic [5:0] rv;
            rv = (k % 2 == 0) ? legal_tab[k % 5] : 6'($urandom_range(0, 63));
            drive(rv[5:3], rv[2:0]);
            tick();
        end
        repeat (20) tick();

        // Reset in the middle of a blink and scan.
        drive(SCALAR_MUL, SCALAR);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (30) tick();

        // One more change after the mid-run reset.
        drive(ADD, DOUBLE);
        repeat (30) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
